// File: rtl/mp_update_scheduler_if.sv
// Bus bundle between the MP update scheduler and its neighbours:
// the MP memory, the adder/threshold unit and the NoC packet injector.
// The master modport is the scheduler side, the slave modport the environment side.
interface mp_update_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 5,
  parameter int PKT_W = 39
);
  logic             mem_rd_en;
  logic [IDX_W-1:0] mem_rd_addr;
  logic [WIDTH-1:0] mem_rd_data;
  logic             mem_wr_en;
  logic [IDX_W-1:0] mem_wr_addr;
  logic [WIDTH-1:0] mem_wr_data;
  logic             add_req_vld;
  logic             add_req_rdy;
  logic [WIDTH-1:0] add_req_mp;
  logic             add_rsp_vld;
  logic             add_rsp_rdy;
  logic [WIDTH:0]   add_rsp_data;
  logic             pkt_vld;
  logic             pkt_rdy;
  logic [PKT_W-1:0] pkt_data;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output add_req_vld, add_req_mp,
    input  add_req_rdy,
    input  add_rsp_vld, add_rsp_data,
    output add_rsp_rdy,
    output pkt_vld, pkt_data,
    input  pkt_rdy
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  add_req_vld, add_req_mp,
    output add_req_rdy,
    output add_rsp_vld, add_rsp_data,
    input  add_rsp_rdy,
    input  pkt_vld, pkt_data,
    output pkt_rdy
  );
endinterface

// File: rtl/mp_update_scheduler.sv
// Membrane-potential update scheduler: sweeps all neurons once per start,
// reading each MP, passing it through the adder/threshold unit, writing the
// new MP back and packing spikes into frames sent as op=1 NoC packets.
// Optional build macro SKIP_ZERO_FRAME_EN: when defined, all-zero spike
// frames are not sent and the sweep continues directly.
module mp_update_scheduler #(
  parameter int WIDTH       = 8,
  parameter int NUM_NEURONS = 25,
  parameter int SPK_W       = 5,
  parameter int ADDR_W      = 4,
  parameter int OP_W        = 2,
  parameter int PKT_W       = 39,
  parameter logic [ADDR_W-1:0] SRC_ADDR  = 4'd0,
  parameter logic [ADDR_W-1:0] DEST_ADDR = 4'd1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  mp_update_scheduler_if.master bus
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int FC_W  = (SPK_W > 1) ? $clog2(SPK_W) : 1;
  localparam int PAD_W = PKT_W - SPK_W - OP_W - 2 * ADDR_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [FC_W-1:0]  LAST_FC  = FC_W'(SPK_W - 1);
  localparam logic [OP_W-1:0]  OP_SPIKE = OP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPT, S_REQ, S_RSP, S_WB, S_SEND, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [IDX_W-1:0]  r_idx;
  logic [FC_W-1:0]   r_frameCnt;
  logic [SPK_W-1:0]  r_frame;
  logic [WIDTH-1:0]  r_mp;
  logic [WIDTH-1:0]  r_newMp;
  logic              r_spike;
  logic [SPK_W-1:0]  w_frameNext;
  logic              w_lastIdx;
  logic              w_lastSlot;
  logic              w_skipZero;

  assign w_lastIdx  = (r_idx == LAST_IDX);
  assign w_lastSlot = (r_frameCnt == LAST_FC);

  // Frame contents as they will be after the current neuron's spike is stored
  always_comb begin
    w_frameNext = r_frame;
    w_frameNext[r_frameCnt] = r_spike;
  end

`ifdef SKIP_ZERO_FRAME_EN
  assign w_skipZero = (w_frameNext == '0);
`else
  assign w_skipZero = 1'b0;
`endif

  // State register; an async reset abandons any sweep in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode and all outputs; every output is zero outside its own state
  always_comb begin
    w_nextState     = r_state;
    busy            = 1'b0;
    done            = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.add_req_vld = 1'b0;
    bus.add_req_mp  = '0;
    bus.add_rsp_rdy = 1'b0;
    bus.pkt_vld     = 1'b0;
    bus.pkt_data    = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_nextState = S_READ;
      end
      S_READ: begin
        busy            = 1'b1;
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = r_idx;
        w_nextState     = S_CAPT;
      end
      S_CAPT: begin
        busy        = 1'b1;
        w_nextState = S_REQ;
      end
      S_REQ: begin
        busy            = 1'b1;
        bus.add_req_vld = 1'b1;
        bus.add_req_mp  = r_mp;
        if (bus.add_req_rdy) w_nextState = S_RSP;
      end
      S_RSP: begin
        busy            = 1'b1;
        bus.add_rsp_rdy = 1'b1;
        if (bus.add_rsp_vld) w_nextState = S_WB;
      end
      S_WB: begin
        busy            = 1'b1;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = r_idx;
        bus.mem_wr_data = r_newMp;
        if (w_lastSlot || w_lastIdx) begin
          if (w_skipZero) begin
            w_nextState = w_lastIdx ? S_DONE : S_READ;
          end else begin
            w_nextState = S_SEND;
          end
        end else begin
          w_nextState = S_READ;
        end
      end
      S_SEND: begin
        busy         = 1'b1;
        bus.pkt_vld  = 1'b1;
        bus.pkt_data = {{PAD_W{1'b0}}, r_frame, OP_SPIKE, SRC_ADDR, DEST_ADDR};
        if (bus.pkt_rdy) w_nextState = w_lastIdx ? S_DONE : S_READ;
      end
      S_DONE: begin
        done        = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath: neuron index, frame slot, spike frame and the captured MP/response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_frameCnt <= '0;
      r_frame    <= '0;
      r_mp       <= '0;
      r_newMp    <= '0;
      r_spike    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx      <= '0;
            r_frameCnt <= '0;
            r_frame    <= '0;
          end
        end
        S_CAPT: r_mp <= bus.mem_rd_data;
        S_RSP: begin
          if (bus.add_rsp_vld) {r_spike, r_newMp} <= bus.add_rsp_data;
        end
        S_WB: begin
          r_frame <= w_frameNext;
          if (w_lastSlot || w_lastIdx) begin
            if (w_skipZero) begin
              r_frameCnt <= '0;
              if (!w_lastIdx) r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_idx      <= r_idx + IDX_W'(1);
            r_frameCnt <= r_frameCnt + FC_W'(1);
          end
        end
        S_SEND: begin
          if (bus.pkt_rdy) begin
            r_frame    <= '0;
            r_frameCnt <= '0;
            if (!w_lastIdx) r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          r_idx      <= '0;
          r_frameCnt <= '0;
          r_frame    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_update_scheduler.sv
// Scoreboard bench for mp_update_scheduler: a 25-neuron instance (A) and a
// 7-neuron instance (B) with memory and adder models; expected writes and
// packets are queued by the stimulus and consumed by negedge monitors.
module tb_mp_update_scheduler;

  localparam int WIDTH = 8;
  localparam int NA    = 25;
  localparam int NB    = 7;
  localparam int IDXA  = 5;
  localparam int IDXB  = 3;
  localparam int PKT_W = 39;

  typedef struct packed {
    logic [IDXA-1:0]  addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic startA = 1'b0;
  logic startB = 1'b0;
  logic busyA, doneA, busyB, doneB;
  logic addRdyA = 1'b1;
  logic pktRdyA = 1'b1;
  logic loadMem = 1'b0;
  int   spikeModeA = 0;

  int checks = 0;
  int errors = 0;
  int doneCntA = 0;
  int doneCntB = 0;

  wr_t              wrQA[$];
  logic [PKT_W-1:0] pktQA[$];
  logic [PKT_W-1:0] pktQB[$];

  logic [WIDTH-1:0] memA[NA];
  logic [WIDTH-1:0] memB[NB];
  logic [WIDTH-1:0] rdA, rdB;
  logic             pendA, pendB;
  logic [WIDTH:0]   rspA, rspB;

  always #5 clk = ~clk;

  mp_update_scheduler_if #(.WIDTH(WIDTH), .IDX_W(IDXA), .PKT_W(PKT_W)) busA ();
  mp_update_scheduler_if #(.WIDTH(WIDTH), .IDX_W(IDXB), .PKT_W(PKT_W)) busB ();

  mp_update_scheduler #(.NUM_NEURONS(NA)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .busy(busyA), .done(doneA), .bus(busA.master)
  );

  mp_update_scheduler #(.NUM_NEURONS(NB)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .busy(busyB), .done(doneB), .bus(busB.master)
  );

  // Memory models: read data valid the cycle after the strobe; loadMem presets contents
  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < NA; i++) memA[i] <= WIDTH'(i);
      for (int i = 0; i < NB; i++) memB[i] <= '0;
    end else begin
      if (busA.mem_rd_en) rdA <= memA[busA.mem_rd_addr];
      if (busA.mem_wr_en) memA[busA.mem_wr_addr] <= busA.mem_wr_data;
      if (busB.mem_rd_en) rdB <= memB[busB.mem_rd_addr];
      if (busB.mem_wr_en) memB[busB.mem_wr_addr] <= busB.mem_wr_data;
    end
  end

  // Adder models: respond the cycle after a request with {spike, mp+1}
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendA <= 1'b0;
      pendB <= 1'b0;
    end else begin
      if (busA.add_req_vld && busA.add_req_rdy) begin
        pendA <= 1'b1;
        rspA  <= {(spikeModeA == 0) ? busA.add_req_mp[0] : 1'b0, busA.add_req_mp + 8'd1};
      end else if (pendA && busA.add_rsp_rdy) begin
        pendA <= 1'b0;
      end
      if (busB.add_req_vld && busB.add_req_rdy) begin
        pendB <= 1'b1;
        rspB  <= {1'b1, busB.add_req_mp + 8'd1};
      end else if (pendB && busB.add_rsp_rdy) begin
        pendB <= 1'b0;
      end
    end
  end

  assign busA.mem_rd_data  = rdA;
  assign busA.add_req_rdy  = addRdyA;
  assign busA.add_rsp_vld  = pendA;
  assign busA.add_rsp_data = rspA;
  assign busA.pkt_rdy      = pktRdyA;
  assign busB.mem_rd_data  = rdB;
  assign busB.add_req_rdy  = 1'b1;
  assign busB.add_rsp_vld  = pendB;
  assign busB.add_rsp_data = rspB;
  assign busB.pkt_rdy      = 1'b1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic reportMissing(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=none required=event", name);
  endtask

  function automatic logic [PKT_W-1:0] mkPkt(input logic [4:0] frame);
    return {24'b0, frame, 2'b01, 4'd0, 4'd1};
  endfunction

  // Monitor A: write and packet scoreboards, done counting, stall stability
  logic             prevPktStall, prevReqStall;
  logic [PKT_W-1:0] prevPkt;
  logic [WIDTH-1:0] prevMp;
  always @(negedge clk) begin
    if (!rst_n) begin
      prevPktStall = 1'b0;
      prevReqStall = 1'b0;
    end else begin
      if (busA.mem_wr_en) begin
        if (wrQA.size() == 0) reportMissing("wrExpectA");
        else checkOutput("wrA", {busA.mem_wr_addr, busA.mem_wr_data}, wrQA.pop_front());
      end
      if (busA.pkt_vld && busA.pkt_rdy) begin
        if (pktQA.size() == 0) reportMissing("pktExpectA");
        else checkOutput("pktA", busA.pkt_data, pktQA.pop_front());
      end
      if (doneA) doneCntA++;
      if (prevPktStall) begin
        checkOutput("pktHold", {busA.pkt_vld, busA.pkt_data}, {1'b1, prevPkt});
        checkOutput("rdInPktStall", busA.mem_rd_en, 1'b0);
      end
      if (prevReqStall) begin
        checkOutput("reqHold", {busA.add_req_vld, busA.add_req_mp}, {1'b1, prevMp});
        checkOutput("rdInReqStall", busA.mem_rd_en, 1'b0);
      end
      prevPktStall = busA.pkt_vld && !busA.pkt_rdy;
      prevReqStall = busA.add_req_vld && !busA.add_req_rdy;
      prevPkt      = busA.pkt_data;
      prevMp       = busA.add_req_mp;
    end
  end

  // Monitor B: packet scoreboard and done counting
  always @(negedge clk) begin
    if (rst_n) begin
      if (busB.pkt_vld && busB.pkt_rdy) begin
        if (pktQB.size() == 0) reportMissing("pktExpectB");
        else checkOutput("pktB", busB.pkt_data, pktQB.pop_front());
      end
      if (doneB) doneCntB++;
    end
  end

  // Pulse start for one clock; returns #1 after the edge that samples it
  task automatic applyStimulus(input bit isB);
    @(negedge clk);
    if (isB) startB = 1'b1;
    else startA = 1'b1;
    @(posedge clk);
    #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  // Counts clock edges from the start edge until done is seen
  task automatic waitDone(input bit isB, input int maxCyc, output int cyc);
    cyc = 1;
    while (cyc <= maxCyc) begin
      @(negedge clk);
      if (isB ? doneB : doneA) break;
      @(posedge clk);
      cyc++;
    end
    if (cyc > maxCyc) reportMissing(isB ? "doneTimeoutB" : "doneTimeoutA");
  endtask

  task automatic checkSweepEnd(input string name, input int d0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput({name, "DoneOnce"}, 64'(doneCntA - d0), 64'd1);
    checkOutput({name, "BusyLow"}, busyA, 1'b0);
    checkOutput({name, "WrQEmpty"}, 64'(wrQA.size()), 64'd0);
    checkOutput({name, "PktQEmpty"}, 64'(pktQA.size()), 64'd0);
  endtask

  logic [4:0] framesT2[5] = '{5'b01010, 5'b10101, 5'b01010, 5'b10101, 5'b01010};
  logic [4:0] framesT3[5] = '{5'b10101, 5'b01010, 5'b10101, 5'b01010, 5'b10101};
  logic [4:0] framesT5[5] = '{5'b10101, 5'b01010, 5'b01001, 5'b10101, 5'b01010};

  initial begin
    int cyc;
    int d0;
    int bad;
    int k;

    // T1 reset: outputs zero while reset is held, memories preset
    #2;
    loadMem = 1'b1;
    @(posedge clk);
    #1;
    loadMem = 1'b0;
    checkOutput("rstCtrlA", {busyA, doneA, busA.mem_rd_en, busA.mem_rd_addr, busA.mem_wr_en,
                busA.mem_wr_addr, busA.mem_wr_data, busA.add_req_vld, busA.add_req_mp,
                busA.add_rsp_rdy, busA.pkt_vld}, 64'd0);
    checkOutput("rstPktA", busA.pkt_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T2 nominal sweep: mem[i]=i, spike=mp%2
    for (int i = 0; i < NA; i++) wrQA.push_back({IDXA'(i), WIDTH'(i + 1)});
    for (int f = 0; f < 5; f++) pktQA.push_back(mkPkt(framesT2[f]));
    d0 = doneCntA;
    applyStimulus(1'b0);
    checkOutput("busyAfterStart", busyA, 1'b1);
    waitDone(1'b0, 400, cyc);
    checkOutput("sweepCycles", 64'(cyc), 64'd131);
    checkSweepEnd("T2", d0);
    bad = 0;
    for (int i = 0; i < NA; i++) if (memA[i] !== WIDTH'(i + 1)) bad++;
    checkOutput("memAfterT2", 64'(bad), 64'd0);

    // T3 backpressure: adder request stalled 3 cycles, packet stalled 10 cycles
    for (int i = 0; i < NA; i++) wrQA.push_back({IDXA'(i), WIDTH'(i + 2)});
    for (int f = 0; f < 5; f++) pktQA.push_back(mkPkt(framesT3[f]));
    d0 = doneCntA;
    addRdyA = 1'b0;
    pktRdyA = 1'b0;
    applyStimulus(1'b0);
    k = 0;
    while (!busA.add_req_vld && k < 20) begin @(negedge clk); k++; end
    if (!busA.add_req_vld) reportMissing("reqSeenT3");
    repeat (3) @(negedge clk);
    addRdyA = 1'b1;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    k = 0;
    while (!busA.pkt_vld && k < 200) begin @(negedge clk); k++; end
    if (!busA.pkt_vld) reportMissing("pktSeenT3");
    repeat (10) @(negedge clk);
    pktRdyA = 1'b1;
    waitDone(1'b0, 400, cyc);
    checkSweepEnd("T3", d0);

    // T5 reset in RSP at idx 12: neurons 0..11 written, frames 0 and 1 sent
    for (int i = 0; i < 12; i++) wrQA.push_back({IDXA'(i), WIDTH'(i + 3)});
    pktQA.push_back(mkPkt(5'b01010));
    pktQA.push_back(mkPkt(5'b10101));
    applyStimulus(1'b0);
    k = 0;
    while (!(busA.mem_wr_en && busA.mem_wr_addr == 5'd11) && k < 200) begin @(negedge clk); k++; end
    if (!busA.mem_wr_en) reportMissing("wr11SeenT5");
    k = 0;
    while (!busA.add_rsp_rdy && k < 20) begin @(negedge clk); k++; end
    if (!busA.add_rsp_rdy) reportMissing("rspSeenT5");
    #1;
    checkOutput("T5WrQEmpty", 64'(wrQA.size()), 64'd0);
    checkOutput("T5PktQEmpty", 64'(pktQA.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstCtrl", {busyA, doneA, busA.mem_rd_en, busA.mem_rd_addr, busA.mem_wr_en,
                busA.mem_wr_addr, busA.mem_wr_data, busA.add_req_vld, busA.add_req_mp,
                busA.add_rsp_rdy, busA.pkt_vld}, 64'd0);
    checkOutput("asyncRstPkt", busA.pkt_data, 64'd0);
    wrQA.delete();
    pktQA.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) if (memA[i] !== WIDTH'(i + 3)) bad++;
    checkOutput("memKeptT5", 64'(bad), 64'd0);
    checkOutput("mem12Untouched", memA[12], 64'd14);

    for (int i = 0; i < NA; i++) wrQA.push_back({IDXA'(i), WIDTH'((i < 12) ? i + 4 : i + 3)});
    for (int f = 0; f < 5; f++) pktQA.push_back(mkPkt(framesT5[f]));
    d0 = doneCntA;
    applyStimulus(1'b0);
    k = 0;
    while (!busA.mem_rd_en && k < 10) begin @(negedge clk); k++; end
    checkOutput("restartAddr", {busA.mem_rd_en, busA.mem_rd_addr}, {1'b1, 5'd0});
    waitDone(1'b0, 400, cyc);
    checkSweepEnd("T5", d0);

    // T6 all spikes zero: frames either skipped or sent as zero
    spikeModeA = 1;
    for (int i = 0; i < NA; i++) wrQA.push_back({IDXA'(i), WIDTH'((i < 12) ? i + 5 : i + 4)});
`ifndef SKIP_ZERO_FRAME_EN
    for (int f = 0; f < 5; f++) pktQA.push_back(mkPkt(5'b00000));
`endif
    d0 = doneCntA;
    applyStimulus(1'b0);
    waitDone(1'b0, 400, cyc);
    checkSweepEnd("T6", d0);

    // T4 partial frame on the 7-neuron instance, every spike 1
    pktQB.push_back(mkPkt(5'b11111));
    pktQB.push_back(mkPkt(5'b00011));
    d0 = doneCntB;
    applyStimulus(1'b1);
    waitDone(1'b1, 100, cyc);
    checkOutput("sweepCyclesB", 64'(cyc), 64'd38);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("T4DoneOnce", 64'(doneCntB - d0), 64'd1);
    checkOutput("T4PktQEmpty", 64'(pktQB.size()), 64'd0);
    bad = 0;
    for (int i = 0; i < NB; i++) if (memB[i] !== 8'd1) bad++;
    checkOutput("memAfterT4", 64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
